bitonic_seq_sorter: RTL

//  Sequential counterpart of the combinational 8-input bitonic sort network.

---
 rtl/bitonic_pkg.sv | 10 +
 rtl/bitonic_seq_sorter_cmp_swap.sv | 15 +
 rtl/bitonic_seq_sorter.sv | 100 ++++++++++
 3 files changed

// File: rtl/bitonic_pkg.sv
// bitonic_pkg: shared constants, layer table and state encoding for the sequential bitonic sorter.
package bitonic_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int N = 8;
  localparam int LAYERS = 6;
  // {d,k} per layer, L0 in the low slot; the two spare slots are never selected
  localparam logic [N-1:0][2:0] LAYER_D = {3'd1, 3'd1, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd1};
  localparam logic [N-1:0][3:0] LAYER_K = {4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd4, 4'd4, 4'd2};
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
endpackage

// File: rtl/bitonic_seq_sorter_cmp_swap.sv
// cmp_swap: unsigned compare-exchange; x gets the smaller value when asc, else the larger.
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             asc,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  logic swap;
  assign swap = asc ? (a > b) : (a < b);
  assign x = swap ? b : a;
  assign y = swap ? a : b;
endmodule

// File: rtl/bitonic_seq_sorter.sv
// bitonic_seq_sorter: serial-in/serial-out 8-entry bitonic sorter, one network layer per cycle.
module bitonic_seq_sorter
  import bitonic_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);
  state_t state, state_n;
  logic [2:0] wr_ptr, wr_n, rd_ptr, rd_n, layer, layer_n;
  logic [WIDTH-1:0] regs [N];
  logic [WIDTH-1:0] regs_n [N];
  logic [2:0] ia [4];
  logic [2:0] ib [4];
  logic [3:0] asc;
  logic [WIDTH-1:0] a [4];
  logic [WIDTH-1:0] b [4];
  logic [WIDTH-1:0] x [4];
  logic [WIDTH-1:0] y [4];
  logic [2:0] d, dm;
  logic [3:0] k;
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy      = state != LOAD;
  assign out_data  = out_valid ? regs[rd_ptr] : '0;
  assign d  = LAYER_D[layer];
  assign k  = LAYER_K[layer];
  assign dm = d - 3'd1;
  // Pair p's low index is p with a zero bit inserted at the position of d
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      ia[p]  = ((3'(p) & ~dm) << 1) | (3'(p) & dm);
      ib[p]  = ia[p] | d;
      asc[p] = ((({1'b0, ia[p]} & k) == 4'd0) ^ DESCEND);
      a[p]   = regs[ia[p]];
      b[p]   = regs[ib[p]];
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_cs
    cmp_swap #(.WIDTH(WIDTH)) u_cs (.a(a[g]), .b(b[g]), .asc(asc[g]), .x(x[g]), .y(y[g]));
  end
  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    layer_n = layer;
    regs_n  = regs;
    case (state)
      LOAD: if (in_valid) begin
        regs_n[wr_ptr] = in_data;
        wr_n = wr_ptr + 3'd1;
        if (wr_ptr == 3'(N - 1)) begin
          state_n = SORT;
          layer_n = '0;
        end
      end
      SORT: begin
        for (int p = 0; p < 4; p++) begin
          regs_n[ia[p]] = x[p];
          regs_n[ib[p]] = y[p];
        end
        layer_n = layer + 3'd1;
        if (layer == 3'(LAYERS - 1)) begin
          state_n = DRAIN;
          layer_n = '0;
          rd_n    = '0;
        end
      end
      DRAIN: if (out_ready) begin
        rd_n = rd_ptr + 3'd1;
        if (rd_ptr == 3'(N - 1)) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_ptr <= '0;
      rd_ptr <= '0;
      layer  <= '0;
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      layer  <= layer_n;
      regs   <= regs_n;
    end
  end
endmodule
